// File: rtl/fnd_pkg.sv
// Definitions shared by the stopwatch counter and the 4-digit FND display
// controller: the count width, the top of the display range and the state
// encoding of the stopwatch control FSM.
package fnd_pkg;

  // Width of the fndData bus between the counter and the display controller.
  localparam int FND_DATA_W = 14;

  // Largest value four decimal digits can show.
  localparam int FND_MAX = 9999;

  // Largest value the fndData bus can carry.
  localparam int FND_LIMIT = (1 << FND_DATA_W) - 1;

  // Stopwatch control states. The encoding is fixed because the display side
  // decodes the same values.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  // Width of a divider that counts 0..div-1. It never drops below one bit,
  // so a divide-by-one build still has a legal vector.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Tick generator for the stopwatch. It divides the system clock by DIV while
// enabled and raises tick for one cycle at the end of each divider period.
// When disabled the divider freezes, so a paused stopwatch keeps its
// sub-step phase.
module stopwatch_tick_gen
  import fnd_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = div_width(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] divider;

  // Divider: zeroed by reset or clear, advances only while enabled, and
  // returns to zero after its last value.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge; blocking assignments here
    // would make the result depend on statement and block ordering.
    if (reset || clr) begin
      divider <= '0;
    end else if (en) begin
      if (divider == LAST) begin
        divider <= '0;
      end else begin
        divider <= divider + DIV_W'(1);
      end
    end
  end

  // The tick coincides with the last divider value. The count register
  // downstream takes the step at the edge that wraps the divider, which
  // gives the one-cycle latency from tick to the new count.
  assign tick = en && (divider == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch counter feeding the FND display controller. A small FSM
// (STOP / RUN / CLR) driven by the run_stop and clear command pulses decides
// when the stopwatch runs. While running, the count steps once per tick, up
// or down as selected by mode_down, and wraps between 0 and MAX_COUNT with a
// one-cycle wrap pulse. fndData is the binary count; BCD conversion is left
// to the display controller.
module stopwatch_counter
  import fnd_pkg::*;
#(
  parameter int SYS_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = FND_MAX   // must be 1..FND_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_stop,
  input  logic                  clear,
  input  logic                  mode_down,
  output logic [FND_DATA_W-1:0] fndData,
  output logic                  running,
  output logic                  wrap
);

  localparam int DIV = SYS_HZ / TICK_HZ;
  localparam logic [FND_DATA_W-1:0] TOP = FND_DATA_W'(MAX_COUNT);

  state_t state;
  logic   tick;

  // The divider runs only in RUN and is zeroed while in CLR. A clear pulse
  // that lands on a tick cycle is handled by the FSM, which drops that step.
  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RUN),
    .clr   (state == ST_CLR),
    .tick  (tick)
  );

  // Control FSM, count register and wrap flag. running is registered next
  // to state, so it is high exactly while the state is RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_STOP;
      running <= 1'b0;
      fndData <= '0;
      wrap    <= 1'b0;
    end else begin
      // wrap is high only in the cycle that shows a wrapped value.
      wrap <= 1'b0;

      case (state)
        ST_STOP: begin
          if (clear) begin
            state   <= ST_CLR;
            running <= 1'b0;
          end else if (run_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (clear) begin
            // clear beats both run_stop and a pending step
            state   <= ST_CLR;
            running <= 1'b0;
          end else begin
            if (run_stop) begin
              state   <= ST_STOP;
              running <= 1'b0;
            end
            // A step due in the same cycle as run_stop is still taken.
            // Both limits are tested before stepping so the count never
            // holds a value outside 0..MAX_COUNT.
            if (tick) begin
              if (mode_down) begin
                if (fndData == '0) begin
                  fndData <= TOP;
                  wrap    <= 1'b1;
                end else begin
                  fndData <= fndData - FND_DATA_W'(1);
                end
              end else begin
                if (fndData == TOP) begin
                  fndData <= '0;
                  wrap    <= 1'b1;
                end else begin
                  fndData <= fndData + FND_DATA_W'(1);
                end
              end
            end
          end
        end

        ST_CLR: begin
          // One cycle of CLR zeroes the count and leaves in STOP. run_stop is
          // ignored here; a clear held high keeps the block in CLR.
          fndData <= '0;
          running <= 1'b0;
          state   <= clear ? ST_CLR : ST_STOP;
        end

        default: begin
          // The unused encoding recovers to a safe stopped state.
          state   <= ST_STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed testbench for stopwatch_counter with SYS_HZ=100 and TICK_HZ=10,
// so one count step every 10 clocks. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, so every expected value below
// is counted in rising edges from a known starting point.
module tb_stopwatch_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_stop = 1'b0;
  logic        clear = 1'b0;
  logic        mode_down = 1'b0;
  logic [13:0] fnd_data;
  logic        running;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_counter #(
    .SYS_HZ    (100),
    .TICK_HZ   (10),
    .MAX_COUNT (9999)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_stop  (run_stop),
    .clear     (clear),
    .mode_down (mode_down),
    .fndData   (fnd_data),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input int expected);
    n_tests++;
    if (actual !== 32'(expected)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle run_stop pulse, sampled at the next edge.
  task automatic pulse_run();
    run_stop = 1'b1;
    cycle(1);
    run_stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(3);
    reset = 1'b0;
  endtask

  initial begin
    // 1. Reset state and idle behaviour.
    cycle(3);
    check("rst_data", fnd_data, 0);
    check("rst_running", running, 0);
    check("rst_wrap", wrap, 0);
    reset = 1'b0;
    cycle(50);
    check("idle_data", fnd_data, 0);
    check("idle_running", running, 0);

    // 2. Count up, 10 edges per step from the run_stop edge, then freeze.
    pulse_run();
    check("run_running", running, 1);
    cycle(9);
    check("up_before_1", fnd_data, 0);
    cycle(1);
    check("up_1", fnd_data, 1);
    check("up_1_wrap", wrap, 0);
    cycle(10);
    check("up_2", fnd_data, 2);
    cycle(10);
    check("up_3", fnd_data, 3);
    pulse_run();
    check("stop_running", running, 0);
    cycle(30);
    check("frozen_data", fnd_data, 3);

    // 3. Wrap in both directions: down 0->9999 (wrap), 9999->9998,
    //    up 9998->9999, 9999->0 (wrap), then down again 0->9999 (wrap).
    do_reset();
    mode_down = 1'b1;
    pulse_run();
    cycle(10);
    check("dn_wrap_data", fnd_data, 9999);
    check("dn_wrap_pulse", wrap, 1);
    cycle(1);
    check("dn_wrap_len", wrap, 0);
    cycle(9);
    check("dn_9998", fnd_data, 9998);
    mode_down = 1'b0;
    cycle(10);
    check("up_9999", fnd_data, 9999);
    check("up_9999_wrap", wrap, 0);
    cycle(10);
    check("up_wrap_data", fnd_data, 0);
    check("up_wrap_pulse", wrap, 1);
    cycle(1);
    check("up_wrap_len", wrap, 0);
    mode_down = 1'b1;
    cycle(9);
    check("dn_wrap2_data", fnd_data, 9999);
    check("dn_wrap2_pulse", wrap, 1);

    // 4. Stop with divider at 6 (it advances to 7 on the stop edge), resume:
    //    the step lands 3 edges after the resume edge, the next 10 later.
    do_reset();
    mode_down = 1'b0;
    pulse_run();
    cycle(6);
    pulse_run();
    check("phase_stopped", running, 0);
    cycle(20);
    check("phase_hold", fnd_data, 0);
    pulse_run();
    cycle(2);
    check("phase_early", fnd_data, 0);
    cycle(1);
    check("phase_step", fnd_data, 1);
    cycle(9);
    check("phase_next_early", fnd_data, 1);
    cycle(1);
    check("phase_next", fnd_data, 2);

    // 5. clear together with run_stop at 42: CLR for one edge, zero the next.
    do_reset();
    pulse_run();
    cycle(420);
    check("at_42", fnd_data, 42);
    clear = 1'b1;
    run_stop = 1'b1;
    cycle(1);
    clear = 1'b0;
    run_stop = 1'b0;
    check("clr_edge1_data", fnd_data, 42);
    check("clr_edge1_running", running, 0);
    cycle(1);
    check("clr_edge2_data", fnd_data, 0);
    check("clr_edge2_running", running, 0);
    cycle(20);
    check("clr_stays_stop", running, 0);
    check("clr_stays_zero", fnd_data, 0);

    // Tick together with run_stop: step taken, then STOP.
    do_reset();
    pulse_run();
    cycle(9);
    pulse_run();
    check("tick_stop_data", fnd_data, 1);
    check("tick_stop_running", running, 0);
    cycle(20);
    check("tick_stop_hold", fnd_data, 1);

    // Tick together with clear: step discarded, count then zeroed.
    pulse_run();
    cycle(9);
    clear = 1'b1;
    cycle(1);
    clear = 1'b0;
    check("tick_clr_no_step", fnd_data, 1);
    check("tick_clr_running", running, 0);
    cycle(1);
    check("tick_clr_zero", fnd_data, 0);

    // 6. Reset mid-run at 17 with divider at 5: immediate zero, no wrap,
    //    and the next run starts a fresh divider period.
    do_reset();
    pulse_run();
    cycle(170);
    check("at_17", fnd_data, 17);
    cycle(5);
    reset = 1'b1;
    cycle(1);
    check("midrst_data", fnd_data, 0);
    check("midrst_running", running, 0);
    check("midrst_wrap", wrap, 0);
    reset = 1'b0;
    pulse_run();
    cycle(9);
    check("rerun_early", fnd_data, 0);
    cycle(1);
    check("rerun_step", fnd_data, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
